// File: rtl/ysyx_23060203_pkg.sv
// ysyx_23060203_pkg: shared IFU state encoding, bus response codes and perf event ids.
package ysyx_23060203_pkg;
  typedef enum logic [1:0] {S_REQ, S_RESP, S_OUT, S_WAIT} ifu_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int PERF_IFU_FETCH = 1;
endpackage

// File: rtl/ysyx_23060203_perf_cnt.sv
// ysyx_23060203_perf_cnt: 64-bit free-wrapping enable counter.
module ysyx_23060203_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] cnt
);
  always_ff @(posedge clk)
    cnt <= rst ? '0 : cnt + {63'd0, en};
endmodule

// File: rtl/ysyx_23060203_ifu.sv
// ysyx_23060203_ifu: single-outstanding instruction fetch over AXI4-Lite read, handing {inst, pc} to IDU.
module ysyx_23060203_ifu
  import ysyx_23060203_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_err,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] dnpc,
  input  logic        dnpc_valid,
  output logic        dnpc_ready
`ifdef YSYX_23060203_IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_wait_cnt
`endif
);
  ifu_state_t state, state_nxt;
  logic ar_fire, r_fire, out_fire, dnpc_fire;
  always_ff @(posedge clk)
    state <= rst ? S_REQ : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   state_nxt = ar_fire ? S_RESP : S_REQ;
      S_RESP:  state_nxt = r_fire ? S_OUT : S_RESP;
      S_OUT:   state_nxt = out_fire ? S_WAIT : S_OUT;
      default: state_nxt = dnpc_fire ? S_REQ : S_WAIT;
    endcase
  end
  always_comb begin
    arvalid    = !rst && state == S_REQ;
    rready     = !rst && state == S_RESP;
    out_valid  = !rst && state == S_OUT;
    dnpc_ready = !rst && state == S_WAIT;
    araddr     = pc;
    ar_fire    = arvalid && arready;
    r_fire     = rready && rvalid;
    out_fire   = out_valid && out_ready;
    dnpc_fire  = dnpc_ready && dnpc_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inst     <= '0;
      inst_err <= 1'b0;
    end else begin
      if (r_fire) begin
        inst     <= rdata;
        inst_err <= rresp != RESP_OKAY;
      end
      if (dnpc_fire) pc <= dnpc;
    end
  end
`ifdef YSYX_23060203_IFU_PERF_EN
  ysyx_23060203_perf_cnt u_fetch_cnt (
    .clk(clk),
    .rst(rst),
    .en (r_fire),
    .cnt(perf_fetch_cnt)
  );
  ysyx_23060203_perf_cnt u_wait_cnt (
    .clk(clk),
    .rst(rst),
    .en (arvalid || rready),
    .cnt(perf_wait_cnt)
  );
`endif
endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// tb_ysyx_23060203_ifu: directed vector table plus randomized fetch stream against a transaction-level model.
module tb_ysyx_23060203_ifu;
  logic        clk = 0, rst = 1;
  logic [31:0] araddr, rdata = 0, inst, pc, dnpc = 0;
  logic        arvalid, arready = 0, rvalid = 0, rready, inst_err, out_valid, out_ready = 0;
  logic        dnpc_valid = 0, dnpc_ready;
  logic [1:0]  rresp = 0;
  int checks = 0, errors = 0, ar_cnt = 0, r_cnt = 0;

  ysyx_23060203_ifu dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc(pc), .inst_err(inst_err), .out_valid(out_valid), .out_ready(out_ready),
    .dnpc(dnpc), .dnpc_valid(dnpc_valid), .dnpc_ready(dnpc_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) begin
      if (arvalid && arready) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready) r_cnt <= r_cnt + 1;
    end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic ar_phase(input int ard, input logic [31:0] epc, input logic noise, input string tag);
    for (int i = 0; i <= ard; i++) begin
      chk({tag, ".arvalid"}, arvalid, 1);
      chk({tag, ".araddr"}, araddr, epc);
      chk({tag, ".rready_req"}, rready, 0);
      chk({tag, ".out_valid_req"}, out_valid, 0);
      arready = i == ard;
      out_ready = noise & $urandom_range(0, 1);
      dnpc_valid = noise & $urandom_range(0, 1);
      dnpc = $urandom;
      @(negedge clk);
    end
    arready = 0;
  endtask

  task automatic r_phase(input int rd, input logic [31:0] data, input logic [1:0] resp, input logic noise, input string tag);
    for (int i = 0; i <= rd; i++) begin
      chk({tag, ".arvalid_resp"}, arvalid, 0);
      chk({tag, ".rready"}, rready, 1);
      chk({tag, ".out_valid_resp"}, out_valid, 0);
      rvalid = i == rd;
      rdata = i == rd ? data : $urandom;
      rresp = i == rd ? resp : 2'($urandom);
      out_ready = noise & $urandom_range(0, 1);
      dnpc_valid = noise & $urandom_range(0, 1);
      dnpc = $urandom;
      @(negedge clk);
    end
    rvalid = 0;
    out_ready = 0;
  endtask

  task automatic out_phase(input int od, input logic [31:0] epc, input logic [31:0] einst, input logic eerr,
                           input logic [31:0] npc, input logic noise, input string tag);
    for (int i = 0; i <= od; i++) begin
      chk({tag, ".out_valid"}, out_valid, 1);
      chk({tag, ".inst"}, inst, einst);
      chk({tag, ".pc"}, pc, epc);
      chk({tag, ".inst_err"}, inst_err, eerr);
      chk({tag, ".arvalid_out"}, arvalid, 0);
      chk({tag, ".dnpc_ready_out"}, dnpc_ready, 0);
      out_ready = i == od;
      dnpc_valid = noise & $urandom_range(0, 1);
      dnpc = $urandom;
      @(negedge clk);
    end
    out_ready = 0;
    chk({tag, ".dnpc_ready"}, dnpc_ready, 1);
    chk({tag, ".out_valid_wait"}, out_valid, 0);
    chk({tag, ".arvalid_wait"}, arvalid, 0);
    dnpc = npc;
    dnpc_valid = 1;
    @(negedge clk);
    dnpc_valid = 0;
  endtask

  task automatic fetch(input int ard, input int rd, input logic [31:0] data, input logic [1:0] resp, input int od,
                       input logic [31:0] npc, input logic [31:0] epc, input logic eerr, input logic noise, input string tag);
    int a0, r0;
    a0 = ar_cnt;
    r0 = r_cnt;
    ar_phase(ard, epc, noise, tag);
    r_phase(rd, data, resp, noise, tag);
    out_phase(od, epc, data, eerr, npc, noise, tag);
    chk({tag, ".ar_count"}, ar_cnt - a0, 1);
    chk({tag, ".r_count"}, r_cnt - r0, 1);
  endtask

  typedef struct {
    int ard, rd, od;
    logic [31:0] data;
    logic [1:0] resp;
    logic [31:0] npc, epc;
    logic eerr, noise;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] mpc, d, n;
  logic [1:0] r;
  int r0;

  initial begin
    vecs[0] = '{0, 0, 5, 32'h0000_0513, 2'b00, 32'h8000_0100, 32'h8000_0000, 1'b0, 1'b0};
    vecs[1] = '{3, 4, 0, 32'h0010_0093, 2'b00, 32'h8000_0203, 32'h8000_0100, 1'b0, 1'b1};
    vecs[2] = '{1, 0, 2, 32'hDEAD_BEEF, 2'b10, 32'hFFFF_FFFC, 32'h8000_0203, 1'b1, 1'b1};
    vecs[3] = '{0, 2, 1, 32'h1234_5678, 2'b01, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b1};
    vecs[4] = '{2, 1, 0, 32'hCAFE_F00D, 2'b11, 32'h8000_1000, 32'h0000_0000, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst.arvalid", arvalid, 0);
    chk("rst.rready", rready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.dnpc_ready", dnpc_ready, 0);
    chk("rst.pc", pc, 32'h8000_0000);
    chk("rst.inst", inst, 0);
    chk("rst.inst_err", inst_err, 0);
    rst = 0;
    @(negedge clk);
    foreach (vecs[i])
      fetch(vecs[i].ard, vecs[i].rd, vecs[i].data, vecs[i].resp, vecs[i].od, vecs[i].npc,
            vecs[i].epc, vecs[i].eerr, vecs[i].noise, $sformatf("vec%0d", i));
    mpc = 32'h8000_1000;
    for (int k = 0; k < 40; k++) begin
      d = $urandom;
      r = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      n = $urandom_range(0, 1) ? $urandom & 32'hFFFF_FFFC : $urandom;
      if (n == 32'h8000_0000) n = 32'h8000_0004;
      fetch($urandom_range(0, 3), $urandom_range(0, 3), d, r, $urandom_range(0, 3), n, mpc,
            r != 2'b00, 1'b1, $sformatf("rnd%0d", k));
      mpc = n;
    end
    // rvalid coinciding with the address handshake must not be taken as the data beat
    r0 = r_cnt;
    chk("same.arvalid", arvalid, 1);
    chk("same.araddr", araddr, mpc);
    arready = 1;
    rvalid = 1;
    rdata = 32'hBAD0_BAD0;
    rresp = 2'b10;
    @(negedge clk);
    arready = 0;
    rvalid = 0;
    chk("same.rready", rready, 1);
    chk("same.out_valid", out_valid, 0);
    chk("same.r_count0", r_cnt - r0, 0);
    r_phase(0, 32'h0000_0073, 2'b00, 1'b0, "same");
    chk("same.r_count1", r_cnt - r0, 1);
    out_phase(1, mpc, 32'h0000_0073, 1'b0, 32'h8000_2000, 1'b0, "same");
    // reset while the data beat is outstanding
    ar_phase(0, 32'h8000_2000, 1'b0, "mid");
    chk("mid.rready", rready, 1);
    rst = 1;
    @(negedge clk);
    chk("mid.arvalid", arvalid, 0);
    chk("mid.out_valid", out_valid, 0);
    chk("mid.rready_rst", rready, 0);
    chk("mid.pc", pc, 32'h8000_0000);
    rst = 0;
    @(negedge clk);
    fetch(0, 0, 32'h0000_0513, 2'b00, 0, 32'h8000_0004, 32'h8000_0000, 1'b0, 1'b0, "post");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
